// File: rtl/alu_pkg.sv
// Shared control-code encodings and FSM state type for the ALU execution unit.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_NOP  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_MULT = 4'b1000;
    localparam logic [3:0] ALU_DIV  = 4'b1001;
    localparam logic [3:0] ALU_XOR  = 4'b1010;
    localparam logic [3:0] ALU_SLL  = 4'b1100;
    localparam logic [3:0] ALU_SRL  = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative signed multiply / restoring divide engine: one step per cycle over
// operand magnitudes, WIDTH steps total, with sign correction on the outputs.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             finish
);

    localparam int CW = $clog2(WIDTH);

    logic             running;
    logic             div_q;
    logic             neg_res;
    logic             neg_rem;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]   q_d;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;

    assign finish = running && (cnt == CW'(WIDTH - 1));

    // {acc, q} is one double-width register: product for mult, remainder:quotient for div.
    // NOTE: every signal assigned in this block gets a default first, so no latch is inferred.
    always_comb begin
        acc_d   = acc;
        q_d     = q;
        sum     = '0;
        shifted = '0;
        diff    = '0;
        if (div_q) begin
            shifted = {acc, q[WIDTH-1]};
            diff    = shifted - {1'b0, mag_b};
            if (!diff[WIDTH]) begin
                acc_d = diff[WIDTH-1:0];
                q_d   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = shifted[WIDTH-1:0];
                q_d   = {q[WIDTH-2:0], 1'b0};
            end
        end else begin
            sum   = q[0] ? ({1'b0, acc} + {1'b0, mag_b}) : {1'b0, acc};
            acc_d = sum[WIDTH:1];
            q_d   = {sum[0], q[WIDTH-1:1]};
        end
    end

    // Quotient sign is a^b; remainder sign follows the dividend.
    always_comb begin
        prod     = {acc, q};
        prod_fix = neg_res ? -prod : prod;
        if (div_q) begin
            hi = neg_rem ? -acc : acc;
            lo = neg_res ? -q : q;
        end else begin
            hi = prod_fix[2*WIDTH-1:WIDTH];
            lo = prod_fix[WIDTH-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            running <= 1'b0;
            div_q   <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            mag_b   <= '0;
            acc     <= '0;
            q       <= '0;
            cnt     <= '0;
        end else if (go) begin
            running <= 1'b1;
            div_q   <= is_div;
            neg_res <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_rem <= a[WIDTH-1];
            mag_b   <= b[WIDTH-1] ? -b : b;
            q       <= a[WIDTH-1] ? -a : a;
            acc     <= '0;
            cnt     <= '0;
        end else if (running) begin
            acc <= acc_d;
            q   <= q_d;
            cnt <= cnt + CW'(1);
            if (finish) running <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_exec.sv
// ALU execution unit: single-cycle datapath, IDLE/ITER/FIX sequencing for the
// iterative mult/div engine, and the registered result/HI/LO outputs.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_start,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [4:0]       alu_shamt,
    output logic             alu_busy,
    output logic             alu_done,
    output logic [WIDTH-1:0] alu_result,
    output logic             alu_zero,
    output logic [WIDTH-1:0] alu_hi,
    output logic [WIDTH-1:0] alu_lo
);

    alu_state_e state_q, state_d;

    logic             accept;
    logic             div_by_zero;
    logic             go;
    logic             md_finish;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] sc_result;

    // Requests while busy are dropped, not queued.
    assign accept      = alu_start && (state_q == IDLE);
    assign div_by_zero = (alu_ctrl == ALU_DIV) && (alu_b == '0);
    assign go          = accept && ((alu_ctrl == ALU_MULT) ||
                                    ((alu_ctrl == ALU_DIV) && !div_by_zero));
    assign alu_busy    = (state_q != IDLE);

    always_comb begin
        sc_result = '0;
        case (alu_ctrl)
            ALU_ADD: sc_result = alu_a + alu_b;
            ALU_SUB: sc_result = alu_a - alu_b;
            ALU_AND: sc_result = alu_a & alu_b;
            ALU_OR:  sc_result = alu_a | alu_b;
            ALU_XOR: sc_result = alu_a ^ alu_b;
            ALU_SLL: sc_result = alu_b << alu_shamt;
            ALU_SRL: sc_result = alu_b >> alu_shamt;
            default: sc_result = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go) state_d = ITER;
            ITER:    if (md_finish) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_done   <= 1'b0;
            alu_result <= '0;
            alu_zero   <= 1'b1;
            alu_hi     <= '0;
            alu_lo     <= '0;
        end else begin
            alu_done <= 1'b0;
            if (state_q == FIX) begin
                alu_done   <= 1'b1;
                alu_hi     <= md_hi;
                alu_lo     <= md_lo;
                alu_result <= md_lo;
                alu_zero   <= (md_lo == '0);
            end else if (accept && !go) begin
                alu_done <= 1'b1;
                if (div_by_zero) begin
                    alu_hi     <= alu_a;
                    alu_lo     <= '1;
                    alu_result <= '1;
                    alu_zero   <= 1'b0;
                end else begin
                    alu_result <= sc_result;
                    alu_zero   <= (sc_result == '0);
                end
            end
        end
    end

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .go     (go),
        .is_div (alu_ctrl == ALU_DIV),
        .a      (alu_a),
        .b      (alu_b),
        .hi     (md_hi),
        .lo     (md_lo),
        .finish (md_finish)
    );

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execution unit that consumes the 4-bit ALU control code produced by the ALU control decoder, together with operands from the register file or immediate path.
- Single-cycle ops (add/sub/and/or/xor/sll/srl) complete with a registered result one cycle after start.
- mult/div run on an iterative 32-step engine that writes HI/LO.
- The datapath stalls on busy.

Parameters:
- WIDTH, 32, operand/result width; the mult/div iteration count equals WIDTH.

Ports:
- clk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- alu_start  in  1  op request; sampled when not busy
- alu_ctrl  in  4  control code: 0010 add, 0110 sub, 0000 and, 0001 or, 1010 xor, 1100 sll, 1101 srl, 1000 mult, 1001 div, 0100 nop
- alu_a  in  WIDTH  operand A (rs)
- alu_b  in  WIDTH  operand B (rt or immediate)
- alu_shamt  in  5  shift amount
- alu_busy  out  1  high while mult/div is iterating
- alu_done  out  1  one-cycle pulse; result/hi/lo valid in this cycle
- alu_result  out  WIDTH  registered result
- alu_zero  out  1  registered (alu_result == 0)
- alu_hi  out  WIDTH  HI register
- alu_lo  out  WIDTH  LO register

Behaviour:
- Reset (async, any time including mid-mult/div):
  - state IDLE
  - alu_busy=0, alu_done=0
  - alu_result=0, alu_zero=1
  - alu_hi=0, alu_lo=0
  - iteration counter cleared
  - no partial HI/LO update survives.
- States:
  - IDLE:
    - start with a single-cycle code -> result registered at the next edge; alu_done=1 for exactly that cycle; stay IDLE. Latency 1.
    - start with 1000/1001 -> latch |a|, |b| and the operand signs; go to ITER.
  - ITER:
    - alu_busy=1.
    - One shift-add (mult) or restoring shift-subtract (div) step per cycle; counter 0..WIDTH-1.
    - After the step at count WIDTH-1, go to FIX.
  - FIX:
    - alu_busy=1.
    - Apply sign correction; write HI/LO and alu_result=LO; go to IDLE with alu_done=1 in the following cycle.
    - Total mult/div latency: start edge to done = WIDTH+2 cycles (34 at default).
- Arithmetic:
  - add/sub wrap modulo 2^WIDTH; no overflow flag or trap.
  - sll = alu_b << shamt; srl = alu_b >> shamt (logical, zero fill).
  - mult: signed, 64-bit product, HI=upper, LO=lower.
  - div: signed; LO=quotient truncated toward zero; HI=remainder, whose sign follows the dividend.
  - Example: -7/2 -> LO=-3, HI=-1.
  - 0x80000000 / -1 -> LO=0x80000000, HI=0.
- Divide by zero:
  - No iteration; IDLE -> done in the next cycle (latency 1).
  - HI=alu_a, LO=0xFFFFFFFF, result=LO, busy never asserts.
- Codes 0100 and undefined codes: result=0, zero=1, done pulse at latency 1, HI/LO unchanged.
- Single-cycle ops never modify HI/LO.
- alu_zero is always updated in the same edge as alu_result.
- Handshake:
  - alu_start while busy=1 is ignored (not queued).
  - alu_start in the cycle alu_done=1 is accepted normally, enabling back-to-back ops.
  - Operands are latched at start; later changes to a/b/ctrl do not affect an in-flight op.
- alu_result holds its last value between ops.

Decomposition:
- Shared package alu_pkg:
  - control-code localparams (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_MULT, ALU_DIV, ALU_NOP)
  - state encoding (IDLE, ITER, FIX)
- One sub-module, alu_muldiv_iter:
  - holds the accumulator/remainder registers, the counter and the sign-fix logic
  - interface: go, is_div, a, b -> hi, lo, finish
  - alu_exec keeps the single-cycle datapath, the FSM/handshake and the output registers.

Test Plan:
- add 0x7FFFFFFF + 1 -> done at cycle 1, result 0x80000000, zero=0. Then sub 5-5 -> result 0, zero=1. HI/LO unchanged.
- sll b=0x1 shamt=31 -> 0x80000000. srl b=0x80000000 shamt=31 -> 0x1. xor 0xFF00FF00^0x0FF00FF0 -> 0xF0F0F0F0.
- mult -3 * 7 -> busy for cycles 1..33, done at cycle 34, HI=0xFFFFFFFF, LO=0xFFFFFFEB, result=LO. Also 0xFFFFFFFF * 0xFFFFFFFF (signed -1*-1) -> HI=0, LO=1.
- div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF at cycle 34. div 10/0 -> done at cycle 1, HI=10, LO=0xFFFFFFFF, busy never high.
- start an add while mult is busy -> ignored, mult result correct. Start an add in the mult's done cycle -> accepted, done one cycle later.
- assert reset at cycle 15 of a div -> all outputs at reset values immediately, with no done pulse. A fresh add after release completes normally.
